// File: rtl/switch_conf_writer_if.sv
// Handshake and bus bundle between the host config loader and switch_conf_writer.
// The host drives the master modport; the writer uses the slave modport.
interface switch_conf_writer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [11:0]           cmd_switch;
  logic [2:0]            cmd_thread;
  logic [ADDR_WIDTH-1:0] cmd_count;
  logic [ADDR_WIDTH-1:0] cmd_loop;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic [63:0]           conf_bus_out;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_switch, cmd_thread, cmd_count, cmd_loop,
    output data_valid, data_in,
    input  cmd_ready, data_ready, conf_bus_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_switch, cmd_thread, cmd_count, cmd_loop,
    input  data_valid, data_in,
    output cmd_ready, data_ready, conf_bus_out, busy, done
  );
endinterface

// File: rtl/switch_conf_writer.sv
// Serialises one program-load command plus its config words into PC_MAX, PC_LOOP and NET_MEM packets.
// Optional macro CONF_WRITER_PARITY_EN: bit 62 carries even parity over the packet.
module switch_conf_writer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  switch_conf_writer_if.slave  bus_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAX  = 2'd1,
    S_LOOP = 2'd2,
    S_MEM  = 2'd3
  } state_e;

  localparam logic [1:0] PKT_PC_MAX  = 2'd1;
  localparam logic [1:0] PKT_PC_LOOP = 2'd2;
  localparam logic [1:0] PKT_NET_MEM = 2'd3;

  state_e                state_q;
  logic                  armed_q;
  logic [11:0]           switch_q;
  logic [2:0]            thread_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] loop_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [63:0]           bus_q;

  logic cmd_fire_d;
  logic data_fire_d;
  logic last_word_d;
  logic addr_max_d;

  function automatic logic [63:0] make_pkt(
    input logic [1:0]  typ,
    input logic [11:0] sw,
    input logic [2:0]  th,
    input logic [12:0] addr,
    input logic [31:0] data
  );
    logic [63:0] p;
    p = {1'b1, 1'b0, typ, sw, th, addr, data};
`ifdef CONF_WRITER_PARITY_EN
    p[62] = ^p[61:0];
`endif
    return p;
  endfunction

  // armed_q keeps cmd_ready low for the whole reset and releases it on the first clock after.
  assign bus_if.cmd_ready    = armed_q && (state_q == S_IDLE);
  assign bus_if.data_ready   = (state_q == S_MEM);
  assign bus_if.conf_bus_out = bus_q;
  assign bus_if.busy         = busy_q;
  assign bus_if.done         = done_q;

  assign cmd_fire_d  = bus_if.cmd_valid && bus_if.cmd_ready;
  assign data_fire_d = bus_if.data_valid && bus_if.data_ready;
  assign last_word_d = (addr_q == count_q);
  assign addr_max_d  = (addr_q == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      switch_q <= '0;
      thread_q <= '0;
      count_q  <= '0;
      loop_q   <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bus_q    <= '0;
    end else begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      bus_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (cmd_fire_d) begin
            switch_q <= bus_if.cmd_switch;
            thread_q <= bus_if.cmd_thread;
            count_q  <= bus_if.cmd_count;
            loop_q   <= bus_if.cmd_loop;
            addr_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MAX;
          end
        end
        S_MAX: begin
          bus_q   <= make_pkt(PKT_PC_MAX, switch_q, thread_q, 13'd0, 32'(count_q));
          state_q <= S_LOOP;
        end
        S_LOOP: begin
          bus_q   <= make_pkt(PKT_PC_LOOP, switch_q, thread_q, 13'd0, 32'(loop_q));
          state_q <= S_MEM;
        end
        S_MEM: begin
          if (data_fire_d) begin
            bus_q <= make_pkt(PKT_NET_MEM, switch_q, thread_q, 13'(addr_q), 32'(bus_if.data_in));
            if (last_word_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (!addr_max_d) begin
              // Saturate rather than wrap; an all-ones count ends the transfer here anyway.
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
